// File: rtl/seq_mul4_pkg.sv
// ============================================================================
// Module : seq_mul4_pkg
// Brief  : Shared widths, state encoding and magnitude helper for seq_mul4.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_mul4_pkg;

  localparam int WIDTH  = 4;
  localparam int PWIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // -8 maps to 4'b1000, which is the correct magnitude when read as unsigned
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x,
                                           input logic             sgn);
    return (sgn && x[WIDTH-1]) ? WIDTH'(~x + 1'b1) : x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_mul4_if.sv
// ============================================================================
// Module : seq_mul4_if
// Brief  : Operand/result bundle between a requester and seq_mul4.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_mul4_if;
  import seq_mul4_pkg::*;

  logic              start;
  logic              sgn;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [PWIDTH-1:0] product;
  logic              busy;
  logic              done;

  modport master (output start, sgn, a, b, input product, busy, done);
  modport slave  (input start, sgn, a, b, output product, busy, done);
endinterface

`default_nettype wire

// File: rtl/seq_mul4_fa4.sv
// ============================================================================
// Module : fa4
// Brief  : 4-bit ripple-carry full adder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fa4 (
  input  wire logic [3:0] a,
  input  wire logic [3:0] b,
  input  wire logic       cin,
  output logic      [3:0] sum,
  output logic            cout
);

  logic [4:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
  end

  assign cout = w_carry[4];

endmodule

`default_nettype wire

// File: rtl/seq_mul4.sv
// ============================================================================
// Module : seq_mul4
// Brief  : 4x4 sequential shift-add multiplier, signed or unsigned operands.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mul4
  import seq_mul4_pkg::*;
(
  input  wire logic clk,
  input  wire logic rst,
  seq_mul4_if.slave bus
);

  state_t            r_state;
  state_t            w_state_next;
  logic [1:0]        r_cnt;
  logic [PWIDTH-1:0] r_acc;
  logic [WIDTH-1:0]  r_mcand;
  logic              r_neg;
  logic [PWIDTH-1:0] r_product;
  logic              r_done;
  logic              w_busy;

  logic [WIDTH-1:0]  w_addend;
  logic [WIDTH-1:0]  w_sum;
  logic              w_cout;

  // Multiplier sits in the low nibble and is consumed LSB first as it shifts out
  assign w_addend = r_acc[0] ? r_mcand : '0;

  fa4 u_fa4 (
    .a    (r_acc[PWIDTH-1:WIDTH]),
    .b    (w_addend),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    case (r_state)
      IDLE: if (bus.start) w_state_next = CALC;
      CALC: begin
        w_busy = 1'b1;
        if (r_cnt == 2'd3) w_state_next = FIX;
      end
      FIX: begin
        w_busy       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_neg     <= 1'b0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_acc   <= {{WIDTH{1'b0}}, mag(bus.b, bus.sgn)};
            r_mcand <= mag(bus.a, bus.sgn);
            r_neg   <= bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_cnt   <= '0;
          end
        end
        CALC: begin
          r_acc <= {w_cout, w_sum, r_acc[WIDTH-1:1]};
          r_cnt <= r_cnt + 2'd1;
        end
        FIX: begin
          r_product <= r_neg ? PWIDTH'(~r_acc + 1'b1) : r_acc;
          r_done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.product = r_product;
  assign bus.busy    = w_busy;
  assign bus.done    = r_done;

endmodule

`default_nettype wire

// File: doc/seq_mul4.md
SEQ_MUL4 -- requirements
Module: seq_mul4

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 4 bits and product width at 8 bits.
REQ-002 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a multiply; sampled on a rising clk edge.
REQ-005 sgn  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 a  input  4  multiplicand; sampled with start.
REQ-007 b  input  4  multiplier; sampled with start.
REQ-008 product  output  8  registered result of the last completed multiply.
REQ-009 busy  output  1  high while an accepted multiply is in progress.
REQ-010 done  output  1  one-cycle pulse marking product valid for a new result.

Function
REQ-011 States SHALL be IDLE, CALC, FIX; encoding is defined in the shared package.
REQ-012 start SHALL be accepted only on an edge where the state is IDLE; at any other time it is ignored.
- No queuing.
REQ-013 On acceptance, the block SHALL capture a, b and sgn, and form magnitudes |a| and |b|.
- Signed mode: |-8| = 4'b1000, treated as unsigned.
- Unsigned mode: magnitudes equal the raw inputs.
- It SHALL also record neg = sgn & (a[3] ^ b[3]), then go to CALC with iteration count 0.
REQ-014 CALC SHALL perform exactly 4 shift-add iterations, one per edge, LSB of multiplier first.
- If the current multiplier bit is 1, add the multiplicand to the accumulator upper nibble through the 4-bit adder with Cin=0.
- Shift the {Cout, sum, lower nibble} right by one.
REQ-015 After the 4th CALC iteration, the state SHALL move to FIX.
REQ-016 In FIX, the block SHALL load product with the 8-bit accumulator, or its two's complement when neg = 1.
- On the same edge it SHALL set done = 1 and return to IDLE.
REQ-017 Latency SHALL be 5 edges from the accepting edge to the edge that raises done.
- busy = 1 from the accepting edge until the FIX edge; busy = 0 whenever done = 1.
REQ-018 done SHALL be high for exactly one cycle per accepted start.
REQ-019 product SHALL hold its value from one FIX edge to the next; it SHALL NOT change during CALC.
REQ-020 start asserted in the cycle where done = 1 SHALL be accepted, giving back-to-back operation with no idle gap.
REQ-021 Input changes on a, b or sgn after acceptance SHALL NOT affect the result in progress.
REQ-022 Results SHALL be exact:
- Unsigned range 0..225.
- Signed range -56..64, e.g. -8 x -8 = 8'h40; no overflow is possible.

Reset
REQ-023 rst = 1 SHALL immediately force:
- state to IDLE;
- product to 8'h00;
- busy and done to 0;
- all internal registers to 0.
REQ-024 Reset asserted mid-operation SHALL abandon the multiply with no done pulse.
- A start on the first edge after rst falls SHALL be accepted normally.

Structure
REQ-025 State encodings, WIDTH=4 and PWIDTH=8 SHALL live in a shared package / include file used by the block and its bench.
REQ-026 The add step SHALL instantiate the team's existing 4-bit full adder FA4 as the single sub-module.
- Its Cout SHALL supply the bit shifted into the accumulator MSB.
REQ-027 Magnitude and final negation SHALL be inline logic (invert and add one), not further sub-modules.

Verification
REQ-028 Unsigned: sgn=0, a=3, b=5, start one cycle -> done 5 edges later, product = 8'h0F, busy high for 5 cycles.
REQ-029 Unsigned max: a=4'hF, b=4'hF, sgn=0 -> product = 8'hE1. Zero: a=0, b=4'h9 -> 8'h00.
REQ-030 Signed: sgn=1, a=4'b1101 (-3), b=5 -> 8'hF1. Signed: a=b=4'b1000 (-8) -> 8'h40. Signed: a=-8, b=7 -> 8'hC8.
REQ-031 start pulsed on the 2nd CALC cycle with new operands -> ignored; original result returned; exactly one done pulse.
REQ-032 Back-to-back: start held high across done -> second multiply accepted on the done cycle; two done pulses 5 cycles apart, both results correct.
REQ-033 rst asserted during CALC -> outputs go to zero asynchronously, with no done.
- The next multiply 2x6 then yields 8'h0C.
